ntt_cmd_ctrl: RTL and testbench

- Command front-end directly upstream of ntt_alu.
- Accepts configuration writes and ALU operation requests from the core over a valid/ready queue.
- Holds the cfg_* registers that drive ntt_alu, pulses op for exactly one cycle, then tracks ntt_alu's done level until completion.
- Returns one tagged response per operation, carrying a cycle count and an error flag.

---
 rtl/bp_common_pkg.sv | 54 +++++
 rtl/ntt_cmd_ctrl_if.sv | 29 ++
 rtl/ntt_cmd_fifo.sv | 51 +++++
 rtl/ntt_cmd_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ntt_cmd_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_common_pkg.sv
// Shared types for the NTT command front-end and the ALU it drives.
package bp_common_pkg;

  localparam int NTT_MAX_LOGN  = 12;
  localparam int NTT_MAX_LOGQ  = 30;
  localparam int NTT_TAG_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CONF  = 3'd1,
    OP_NTT   = 3'd2,
    OP_INTT  = 3'd3,
    OP_PWMUL = 3'd4,
    OP_ADD   = 3'd5,
    OP_SUB   = 3'd6
  } alu_op_e;

  typedef enum logic {
    CMD_CFG = 1'b0,
    CMD_OP  = 1'b1
  } ntt_cmd_type_e;

  typedef enum logic [2:0] {
    SEL_LOGN  = 3'd0,
    SEL_Q     = 3'd1,
    SEL_R     = 3'd2,
    SEL_W     = 3'd3,
    SEL_PHI   = 3'd4,
    SEL_N_INV = 3'd5
  } ntt_cfg_sel_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } ntt_ctrl_state_e;

  // sel is kept as raw bits so the unused codes 6/7 survive the queue and can be dropped
  typedef struct packed {
    ntt_cmd_type_e              cmd_type;
    logic [2:0]                 sel;
    alu_op_e                    op;
    logic [NTT_MAX_LOGQ:0]      data;
    logic [NTT_TAG_WIDTH-1:0]   tag;
  } ntt_cmd_s;

  // Cycle counter increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ntt_cmd_ctrl_if.sv
// Command / response handshake between the core (master) and ntt_cmd_ctrl (slave).
interface ntt_cmd_ctrl_if;
  import bp_common_pkg::*;

  logic                       cmd_v;
  logic                       cmd_ready;
  ntt_cmd_type_e              cmd_type;
  logic [2:0]                 cmd_sel;
  alu_op_e                    cmd_op;
  logic [NTT_MAX_LOGQ:0]      cmd_data;
  logic [NTT_TAG_WIDTH-1:0]   cmd_tag;

  logic                       resp_v;
  logic                       resp_ready;
  logic [NTT_TAG_WIDTH-1:0]   resp_tag;
  logic                       resp_err;
  logic [31:0]                resp_cycles;

  modport master (
    output cmd_v, cmd_type, cmd_sel, cmd_op, cmd_data, cmd_tag, resp_ready,
    input  cmd_ready, resp_v, resp_tag, resp_err, resp_cycles
  );

  modport slave (
    input  cmd_v, cmd_type, cmd_sel, cmd_op, cmd_data, cmd_tag, resp_ready,
    output cmd_ready, resp_v, resp_tag, resp_err, resp_cycles
  );

endinterface

// File: rtl/ntt_cmd_fifo.sv
// Small synchronous command queue; the head entry is visible combinationally on rdata_o.
module ntt_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries below count_q are ever read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ntt_cmd_ctrl.sv
// Command front-end for ntt_alu: queues commands, owns the cfg registers,
// issues one-cycle op pulses and returns a tagged, timed response per op.
module ntt_cmd_ctrl
  import bp_common_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ntt_cmd_ctrl_if.slave           cmd_if,
  output logic [NTT_MAX_LOGN-1:0] cfg_logn_o,
  output logic [NTT_MAX_LOGQ-1:0] cfg_q_o,
  output logic [NTT_MAX_LOGQ:0]   cfg_r_o,
  output logic [NTT_MAX_LOGQ-1:0] cfg_w_o,
  output logic [NTT_MAX_LOGQ-1:0] cfg_phi_o,
  output logic [NTT_MAX_LOGQ-1:0] cfg_n_inv_o,
  output alu_op_e                 op_o,
  input  logic                    done_i,
  output logic                    busy_o
);

  localparam int CMD_W = $bits(ntt_cmd_s);

  ntt_cmd_s               push_cmd, head_cmd;
  logic [CMD_W-1:0]       head_bits;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;

  ntt_ctrl_state_e        state_q, state_d;
  alu_op_e                op_q, op_d;
  logic [NTT_TAG_WIDTH-1:0] tag_q, tag_d;
  logic                   err_q, err_d;
  logic [31:0]            cycles_q, cycles_d;
  logic [NTT_MAX_LOGN-1:0] logn_q, logn_d;
  logic [NTT_MAX_LOGQ-1:0] q_q, q_d, w_q, w_d, phi_q, phi_d, ninv_q, ninv_d;
  logic [NTT_MAX_LOGQ:0]  r_q, r_d;

  // Pack the incoming command fields into one queue entry
  always_comb begin
    push_cmd.cmd_type = cmd_if.cmd_type;
    push_cmd.sel      = cmd_if.cmd_sel;
    push_cmd.op       = cmd_if.cmd_op;
    push_cmd.data     = cmd_if.cmd_data;
    push_cmd.tag      = cmd_if.cmd_tag;
  end

  assign cmd_if.cmd_ready = rst_n & ~fifo_full;
  assign fifo_push        = cmd_if.cmd_v & cmd_if.cmd_ready;
  assign head_cmd         = ntt_cmd_s'(head_bits);

  ntt_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (push_cmd),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state logic: cfg writes only in IDLE so cfg stays frozen while the ALU runs
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    err_d    = err_q;
    cycles_d = cycles_q;
    logn_d   = logn_q;
    q_d      = q_q;
    r_d      = r_q;
    w_d      = w_q;
    phi_d    = phi_q;
    ninv_d   = ninv_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && done_i) begin
          fifo_pop = 1'b1;
          if (head_cmd.cmd_type == CMD_CFG) begin
            case (head_cmd.sel)
              SEL_LOGN:  logn_d = head_cmd.data[NTT_MAX_LOGN-1:0];
              SEL_Q:     q_d    = head_cmd.data[NTT_MAX_LOGQ-1:0];
              SEL_R:     r_d    = head_cmd.data;
              SEL_W:     w_d    = head_cmd.data[NTT_MAX_LOGQ-1:0];
              SEL_PHI:   phi_d  = head_cmd.data[NTT_MAX_LOGQ-1:0];
              SEL_N_INV: ninv_d = head_cmd.data[NTT_MAX_LOGQ-1:0];
              default:   ;
            endcase
          end else if (head_cmd.op == OP_NOP) begin
            tag_d    = head_cmd.tag;
            err_d    = 1'b1;
            cycles_d = 32'd0;
            state_d  = S_RESP;
          end else begin
            op_d    = head_cmd.op;
            tag_d   = head_cmd.tag;
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cycles_d = 32'd1;
        state_d  = S_ARM;
      end
      S_ARM: begin
        if (done_i) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cycles_d = sat_inc32(cycles_q);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_i) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cycles_d = sat_inc32(cycles_q);
        end
      end
      S_RESP: begin
        if (cmd_if.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, response payload and cfg registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      tag_q    <= '0;
      err_q    <= 1'b0;
      cycles_q <= '0;
      logn_q   <= '0;
      q_q      <= '0;
      r_q      <= '0;
      w_q      <= '0;
      phi_q    <= '0;
      ninv_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
      logn_q   <= logn_d;
      q_q      <= q_d;
      r_q      <= r_d;
      w_q      <= w_d;
      phi_q    <= phi_d;
      ninv_q   <= ninv_d;
    end
  end

  assign op_o               = (state_q == S_ISSUE) ? op_q : OP_NOP;
  assign busy_o             = (state_q != S_IDLE) | ~fifo_empty;
  assign cmd_if.resp_v      = (state_q == S_RESP);
  assign cmd_if.resp_tag    = tag_q;
  assign cmd_if.resp_err    = err_q;
  assign cmd_if.resp_cycles = cycles_q;
  assign cfg_logn_o         = logn_q;
  assign cfg_q_o            = q_q;
  assign cfg_r_o            = r_q;
  assign cfg_w_o            = w_q;
  assign cfg_phi_o          = phi_q;
  assign cfg_n_inv_o        = ninv_q;

endmodule

// File: tb/tb_ntt_cmd_ctrl.sv
// Directed self-checking bench for ntt_cmd_ctrl with a behavioural ntt_alu done model.
module tb_ntt_cmd_ctrl;
  import bp_common_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [NTT_MAX_LOGN-1:0] cfgLogn;
  logic [NTT_MAX_LOGQ-1:0] cfgQ, cfgW, cfgPhi, cfgNinv;
  logic [NTT_MAX_LOGQ:0]   cfgR;
  alu_op_e opSig;
  logic doneSig, busySig;

  logic aluDone;
  int   aluCnt;
  int   busyLen   = 20;
  logic ignoreOp  = 1'b0;
  logic forceBusy = 1'b0;

  int opPulseCount = 0;
  alu_op_e lastOp = OP_NOP;
  int checkCount = 0;
  int errorCount = 0;
  int pulseBase;

  ntt_cmd_ctrl_if cmdIf();

  ntt_cmd_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_if      (cmdIf),
    .cfg_logn_o  (cfgLogn),
    .cfg_q_o     (cfgQ),
    .cfg_r_o     (cfgR),
    .cfg_w_o     (cfgW),
    .cfg_phi_o   (cfgPhi),
    .cfg_n_inv_o (cfgNinv),
    .op_o        (opSig),
    .done_i      (doneSig),
    .busy_o      (busySig)
  );

  always #5 clk = ~clk;

  assign doneSig = aluDone & ~forceBusy;

  // ALU model: after sampling an op, done drops for busyLen cycles (unless ignoreOp)
  always @(posedge clk) begin
    if (!rst_n) begin
      aluDone <= 1'b1;
      aluCnt  <= 0;
    end else if (opSig != OP_NOP && !ignoreOp) begin
      aluDone <= 1'b0;
      aluCnt  <= busyLen;
    end else if (aluCnt > 1) begin
      aluCnt <= aluCnt - 1;
    end else if (aluCnt == 1) begin
      aluCnt  <= 0;
      aluDone <= 1'b1;
    end
  end

  // Count every cycle on which an op pulse is visible
  always @(negedge clk) begin
    if (opSig != OP_NOP) begin
      opPulseCount <= opPulseCount + 1;
      lastOp       <= opSig;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Push one command; called at a negedge, returns at the negedge after the push
  task automatic applyStimulus(input ntt_cmd_type_e t, input logic [2:0] sel, input alu_op_e op,
                               input logic [NTT_MAX_LOGQ:0] data, input logic [NTT_TAG_WIDTH-1:0] tag);
    int waitCycles = 0;
    cmdIf.cmd_v    = 1'b1;
    cmdIf.cmd_type = t;
    cmdIf.cmd_sel  = sel;
    cmdIf.cmd_op   = op;
    cmdIf.cmd_data = data;
    cmdIf.cmd_tag  = tag;
    while (!cmdIf.cmd_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!cmdIf.cmd_ready) checkOutput("push_timeout", cmdIf.cmd_ready, 1);
    @(negedge clk);
    cmdIf.cmd_v = 1'b0;
  endtask

  task automatic waitResp();
    int n = 0;
    while (!cmdIf.resp_v && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp_valid", cmdIf.resp_v, 1);
  endtask

  task automatic ackResp();
    cmdIf.resp_ready = 1'b1;
    @(negedge clk);
    cmdIf.resp_ready = 1'b0;
  endtask

  // Directed test sequence
  initial begin
    cmdIf.cmd_v = 1'b0; cmdIf.cmd_type = CMD_CFG; cmdIf.cmd_sel = '0;
    cmdIf.cmd_op = OP_NOP; cmdIf.cmd_data = '0; cmdIf.cmd_tag = '0;
    cmdIf.resp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", cmdIf.cmd_ready, 0);
    checkOutput("rst_busy", busySig, 0);
    checkOutput("rst_resp_v", cmdIf.resp_v, 0);
    checkOutput("rst_op", opSig, OP_NOP);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", cmdIf.cmd_ready, 1);
    checkOutput("post_rst_cycles", cmdIf.resp_cycles, 0);
    checkOutput("post_rst_tag", cmdIf.resp_tag, 0);

    // Six cfg writes plus a dropped sel=6 write, then OP_CONF with a 20-cycle ALU
    applyStimulus(CMD_CFG, 3'd0, OP_NOP, 31'd4, 4'd0);
    applyStimulus(CMD_CFG, 3'd1, OP_NOP, 31'd12289, 4'd0);
    applyStimulus(CMD_CFG, 3'd2, OP_NOP, 31'h5555_1234, 4'd0);
    applyStimulus(CMD_CFG, 3'd3, OP_NOP, 31'h7FFF_FFFF, 4'd0);
    applyStimulus(CMD_CFG, 3'd4, OP_NOP, 31'd49, 4'd0);
    applyStimulus(CMD_CFG, 3'd5, OP_NOP, 31'd12265, 4'd0);
    applyStimulus(CMD_CFG, 3'd6, OP_NOP, 31'd777, 4'd0);
    busyLen = 20;
    pulseBase = opPulseCount;
    applyStimulus(CMD_OP, 3'd0, OP_CONF, 31'd0, 4'd5);
    waitResp();
    checkOutput("conf_tag", cmdIf.resp_tag, 5);
    checkOutput("conf_err", cmdIf.resp_err, 0);
    checkOutput("conf_cycles", cmdIf.resp_cycles, 21);
    checkOutput("conf_pulses", opPulseCount - pulseBase, 1);
    checkOutput("conf_lastop", lastOp, OP_CONF);
    checkOutput("cfg_logn", cfgLogn, 4);
    checkOutput("cfg_q", cfgQ, 12289);
    checkOutput("cfg_r", cfgR, 31'h5555_1234);
    checkOutput("cfg_w_trunc", cfgW, 30'h3FFF_FFFF);
    checkOutput("cfg_phi", cfgPhi, 49);
    checkOutput("cfg_ninv", cfgNinv, 12265);
    checkOutput("conf_busy", busySig, 1);
    ackResp();
    checkOutput("conf_resp_cleared", cmdIf.resp_v, 0);

    // Fill the queue while the ALU reports busy
    forceBusy = 1'b1;
    busyLen = 3;
    for (int i = 1; i <= 4; i++) begin
      checkOutput("fill_ready", cmdIf.cmd_ready, 1);
      applyStimulus(CMD_OP, 3'd0, (i % 2 == 1) ? OP_NTT : OP_INTT, 31'd0, 4'(i));
    end
    checkOutput("full_ready", cmdIf.cmd_ready, 0);
    cmdIf.cmd_v = 1'b1; cmdIf.cmd_type = CMD_OP; cmdIf.cmd_op = OP_ADD; cmdIf.cmd_tag = 4'd9;
    repeat (3) @(negedge clk);
    cmdIf.cmd_v = 1'b0;
    checkOutput("full_still", cmdIf.cmd_ready, 0);
    checkOutput("full_no_issue", opSig, OP_NOP);
    forceBusy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      waitResp();
      checkOutput("fifo_order_tag", cmdIf.resp_tag, i);
      checkOutput("fifo_err", cmdIf.resp_err, 0);
      checkOutput("fifo_cycles", cmdIf.resp_cycles, 4);
      ackResp();
    end
    repeat (4) @(negedge clk);
    checkOutput("drain_no_fifth", cmdIf.resp_v, 0);
    checkOutput("drain_busy", busySig, 0);

    // OP_NOP returns an error without ever pulsing op
    pulseBase = opPulseCount;
    applyStimulus(CMD_OP, 3'd0, OP_NOP, 31'd0, 4'd7);
    waitResp();
    checkOutput("nop_tag", cmdIf.resp_tag, 7);
    checkOutput("nop_err", cmdIf.resp_err, 1);
    checkOutput("nop_cycles", cmdIf.resp_cycles, 0);
    checkOutput("nop_pulses", opPulseCount - pulseBase, 0);
    ackResp();

    // ALU ignores the op: ARM sees done still high
    ignoreOp = 1'b1;
    pulseBase = opPulseCount;
    applyStimulus(CMD_OP, 3'd0, OP_NTT, 31'd0, 4'd3);
    waitResp();
    checkOutput("ign_tag", cmdIf.resp_tag, 3);
    checkOutput("ign_err", cmdIf.resp_err, 1);
    checkOutput("ign_cycles", cmdIf.resp_cycles, 1);
    checkOutput("ign_pulses", opPulseCount - pulseBase, 1);
    ackResp();
    ignoreOp = 1'b0;

    // Back-pressured response: payload stable, next op waits for the handshake
    busyLen = 2;
    applyStimulus(CMD_OP, 3'd0, OP_NTT, 31'd0, 4'd10);
    applyStimulus(CMD_OP, 3'd0, OP_INTT, 31'd0, 4'd11);
    waitResp();
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_v", cmdIf.resp_v, 1);
      checkOutput("hold_tag", cmdIf.resp_tag, 10);
      checkOutput("hold_cycles", cmdIf.resp_cycles, 3);
      checkOutput("hold_op", opSig, OP_NOP);
      @(negedge clk);
    end
    ackResp();
    checkOutput("hs_resp_v", cmdIf.resp_v, 0);
    checkOutput("hs_no_issue", opSig, OP_NOP);
    @(negedge clk);
    checkOutput("hs_issue", opSig, OP_INTT);
    waitResp();
    checkOutput("second_tag", cmdIf.resp_tag, 11);
    checkOutput("second_cycles", cmdIf.resp_cycles, 3);
    ackResp();

    // Reset while waiting on the ALU with three entries queued
    busyLen = 50;
    applyStimulus(CMD_OP, 3'd0, OP_NTT, 31'd0, 4'd1);
    applyStimulus(CMD_OP, 3'd0, OP_NTT, 31'd0, 4'd2);
    applyStimulus(CMD_OP, 3'd0, OP_NTT, 31'd0, 4'd3);
    applyStimulus(CMD_OP, 3'd0, OP_NTT, 31'd0, 4'd4);
    @(negedge clk);
    checkOutput("wait_busy", busySig, 1);
    checkOutput("wait_ready", cmdIf.cmd_ready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", cmdIf.cmd_ready, 0);
    checkOutput("midrst_busy", busySig, 0);
    checkOutput("midrst_logn", cfgLogn, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_rst_ready", cmdIf.cmd_ready, 1);
    checkOutput("after_rst_busy", busySig, 0);
    checkOutput("after_rst_resp_v", cmdIf.resp_v, 0);
    checkOutput("after_rst_q", cfgQ, 0);
    checkOutput("after_rst_cycles", cmdIf.resp_cycles, 0);
    repeat (5) @(negedge clk);
    checkOutput("after_rst_idle", busySig, 0);
    checkOutput("after_rst_no_op", opSig, OP_NOP);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
